register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised two-read/one-write register file with write-through bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard. It replaces the fixed 8x16 register file in the datapath. The scoreboard lets the control unit mark a destination register as pending when a multi-cycle result is issued. The register clears the mark when that result is written back.

## Interface
- WIDTH, 16, data width of every register and of W/R/S
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 always reads 0, never becomes busy, and ignores writes and locks
- BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to R/S

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- W  in  WIDTH  write data
- W_Adr  in  ADDR_W  write address
- we  in  1  write enable
- R_Adr  in  ADDR_W  read port R address
- S_Adr  in  ADDR_W  read port S address
- lock  in  1  set busy bit of L_Adr at next edge
- L_Adr  in  ADDR_W  lock address
- flush  in  1  clear all busy bits at next edge
- R  out  WIDTH  read data, port R
- S  out  WIDTH  read data, port S
- R_busy  out  1  busy bit of R_Adr
- S_busy  out  1  busy bit of S_Adr
- any_busy  out  1  OR of all busy bits

## Operation
- Storage: DEPTH x WIDTH registers plus DEPTH busy bits. Reset value of every register and busy bit is 0.
- Outputs during and after reset:
  - R, S = 0 while reset is high, except when BYPASS forwards W.
  - R_busy, S_busy and any_busy = 0.
- Write: on a rising edge with we=1, reg[W_Adr] <= W.
  - With ZERO_REG=1 and W_Adr=0, the write is dropped.
- Reads are combinational. R = reg[R_Adr], S = reg[S_Adr]; both ports are independent and may use the same address.
- Bypass: with BYPASS=1, we=1 and R_Adr==W_Adr, R = W in the same cycle. The same rule applies to S.
  - Bypass is suppressed for address 0 when ZERO_REG=1.
  - With BYPASS=0, R and S show the old value until after the edge.
- Busy bits are updated on each rising edge, in this priority order:
  1. flush=1: all bits <= 0. lock in the same cycle is then applied on top, so busy[L_Adr] <= 1.
  2. Otherwise, we=1 clears busy[W_Adr].
  3. lock=1 sets busy[L_Adr].
- lock and we to the same address in the same cycle leaves busy = 1: the new producer wins.
- R_busy/S_busy are read combinationally from the registered bits and are never bypassed.
- ZERO_REG=1: busy[0] stays 0 at all times.
- Writing to a non-busy register is legal and leaves its busy bit at 0.
- Locking an already-busy register is legal; the bit stays 1.
- Address arithmetic: unsigned ADDR_W bits; no out-of-range addresses exist.

## Timing
- Write latency: 1 edge. Data is visible on R/S in the cycle after the edge, or in the same cycle via bypass.
- Lock/flush latency: 1 edge until R_busy/S_busy/any_busy change.
- Reset is asynchronous. Asserting it mid-write or mid-lock discards that operation. State is 0 immediately, not at the next edge.
- After reset deasserts, the first rising edge is a normal operating edge.
- Bench convention: drive inputs at the falling edge, sample outputs 1 ns after the rising edge.

## Test plan
- Reset, then sweep R_Adr 0..7 and S_Adr 7..0 with we=0 -> R=S=16'h0000 and R_busy=S_busy=any_busy=0 for every address.
- Write W=~addr to addresses 0..7 (ZERO_REG=0), then read back the same sweep -> R_Adr=3 gives R=16'hFFFC, and S_Adr=4 gives S=16'hFFFB.
- BYPASS=1: we=1, W_Adr=5, W=16'hA5A5, R_Adr=5 in the same cycle -> R=16'hA5A5 before the edge.
  - Same stimulus with BYPASS=0 -> old value before the edge, 16'hA5A5 after.
- ZERO_REG=1: write 16'h1234 to address 0 and lock address 0 -> R=0 and R_busy=0 afterwards. A write of 16'h1234 to address 1 reads back 16'h1234.
- Scoreboard sequence:
  - lock L_Adr=2 -> R_busy=1 and any_busy=1 next cycle.
  - we W_Adr=2 together with lock L_Adr=2 -> busy stays 1.
  - we W_Adr=2 alone -> busy clears to 0.
  - lock 6, then flush with lock 3 -> only busy[3]=1.
- Assert reset asynchronously mid-cycle after registers hold nonzero data and busy bits are set -> R=S=0 and all busy outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - two-read/one-write register file with bypass and busy scoreboard
module register_file_sb #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  W,
    input  logic [ADDR_W-1:0] W_Adr,
    input  logic              we,
    input  logic [ADDR_W-1:0] R_Adr,
    input  logic [ADDR_W-1:0] S_Adr,
    input  logic              lock,
    input  logic [ADDR_W-1:0] L_Adr,
    input  logic              flush,
    output logic [WIDTH-1:0]  R,
    output logic [WIDTH-1:0]  S,
    output logic              R_busy,
    output logic              S_busy,
    output logic              any_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             write_ok;
    logic             r_fwd;
    logic             s_fwd;

    // A write to the hardwired-zero register is dropped everywhere, including the bypass path.
    assign write_ok = we && !((ZERO_REG != 0) && (W_Adr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[W_Adr] <= W;
        end
    end

    // Lock is applied last so a new producer wins over a writeback or flush in the same cycle.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else if (we) begin
            busy_nxt[W_Adr] = 1'b0;
        end
        if (lock) begin
            busy_nxt[L_Adr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign r_fwd = (BYPASS != 0) && write_ok && (R_Adr == W_Adr);
    assign s_fwd = (BYPASS != 0) && write_ok && (S_Adr == W_Adr);

    assign R        = r_fwd ? W : regs[R_Adr];
    assign S        = s_fwd ? W : regs[S_Adr];
    assign R_busy   = busy[R_Adr];
    assign S_busy   = busy[S_Adr];
    assign any_busy = |busy;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - scoreboard bench for register_file_sb in three configurations
module tb_register_file_sb;

    logic        clk;
    logic        reset;
    logic [15:0] W;
    logic [2:0]  W_Adr;
    logic        we;
    logic [2:0]  R_Adr;
    logic [2:0]  S_Adr;
    logic        lock;
    logic [2:0]  L_Adr;
    logic        flush;

    logic [15:0] R_d, S_d, R_n, S_n, R_z, S_z;
    logic        Rb_d, Sb_d, Ab_d, Rb_n, Sb_n, Ab_n, Rb_z, Sb_z, Ab_z;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    register_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .W(W), .W_Adr(W_Adr), .we(we),
        .R_Adr(R_Adr), .S_Adr(S_Adr), .lock(lock), .L_Adr(L_Adr), .flush(flush),
        .R(R_d), .S(S_d), .R_busy(Rb_d), .S_busy(Sb_d), .any_busy(Ab_d)
    );

    register_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .W(W), .W_Adr(W_Adr), .we(we),
        .R_Adr(R_Adr), .S_Adr(S_Adr), .lock(lock), .L_Adr(L_Adr), .flush(flush),
        .R(R_n), .S(S_n), .R_busy(Rb_n), .S_busy(Sb_n), .any_busy(Ab_n)
    );

    register_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk(clk), .reset(reset), .W(W), .W_Adr(W_Adr), .we(we),
        .R_Adr(R_Adr), .S_Adr(S_Adr), .lock(lock), .L_Adr(L_Adr), .flush(flush),
        .R(R_z), .S(S_z), .R_busy(Rb_z), .S_busy(Sb_z), .any_busy(Ab_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [15:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic chk(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        total++;
        if (tag_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic pc(input string tag, input logic [15:0] exp, input logic [15:0] obs);
        push(tag, exp);
        chk(obs);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b1; W = '0; W_Adr = '0; we = 1'b0; R_Adr = '0; S_Adr = '0;
        lock = 1'b0; L_Adr = '0; flush = 1'b0;

        @(negedge clk);
        #1;
        pc("reset_R", 16'h0000, R_d);
        pc("reset_any_busy", 16'h0000, {15'b0, Ab_d});
        @(negedge clk);
        reset = 1'b0;

        // Post-reset sweep.
        for (int i = 0; i < 8; i++) begin
            R_Adr = 3'(i);
            S_Adr = 3'(7 - i);
            #1;
            pc($sformatf("init_R[%0d]", i), 16'h0000, R_d);
            pc($sformatf("init_S[%0d]", 7 - i), 16'h0000, S_d);
            pc($sformatf("init_busy[%0d]", i), 16'h0000, {13'b0, Rb_d, Sb_d, Ab_d});
        end

        // Write ~addr everywhere; expectations queued at write time, checked at readback.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = 16'(i);
            we = 1'b1; W_Adr = 3'(i); W = ~v;
            push($sformatf("wr_R[%0d]", i), ~v);
            push($sformatf("wr_Rz[%0d]", i), (i == 0) ? 16'h0000 : ~v);
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            R_Adr = 3'(i);
            S_Adr = 3'(7 - i);
            #1;
            chk(R_d);
            chk(R_z);
        end
        R_Adr = 3'd3; S_Adr = 3'd4;
        #1;
        pc("rd_R3", 16'hFFFC, R_d);
        pc("rd_S4", 16'hFFFB, S_d);
        pc("rd_nb_S4", 16'hFFFB, S_n);

        // Bypass vs no bypass.
        @(negedge clk);
        we = 1'b1; W_Adr = 3'd5; W = 16'hA5A5; R_Adr = 3'd5; S_Adr = 3'd5;
        #1;
        pc("byp_R", 16'hA5A5, R_d);
        pc("byp_S", 16'hA5A5, S_d);
        pc("nobyp_R_before", 16'hFFFA, R_n);
        edge_sample();
        pc("nobyp_R_after", 16'hA5A5, R_n);

        // Hardwired zero register.
        @(negedge clk);
        we = 1'b1; W_Adr = 3'd0; W = 16'h1234; lock = 1'b1; L_Adr = 3'd0; R_Adr = 3'd0;
        #1;
        pc("z_R0_nobyp", 16'h0000, R_z);
        edge_sample();
        pc("z_R0", 16'h0000, R_z);
        pc("z_R0_busy", 16'h0000, {15'b0, Rb_z});
        pc("z_any_busy", 16'h0000, {15'b0, Ab_z});
        pc("nz_R0", 16'h1234, R_d);
        pc("nz_R0_busy_we_lock", 16'h0001, {15'b0, Rb_d});
        @(negedge clk);
        lock = 1'b0; W_Adr = 3'd1; R_Adr = 3'd1;
        edge_sample();
        pc("z_R1", 16'h1234, R_z);
        @(negedge clk);
        we = 1'b0; flush = 1'b1;
        edge_sample();
        pc("flush_any_busy", 16'h0000, {15'b0, Ab_d});
        @(negedge clk);
        flush = 1'b0;

        // Scoreboard sequence.
        lock = 1'b1; L_Adr = 3'd2; R_Adr = 3'd2;
        #1;
        pc("lock2_before_edge", 16'h0000, {15'b0, Rb_d});
        edge_sample();
        pc("lock2_R_busy", 16'h0001, {15'b0, Rb_d});
        pc("lock2_any_busy", 16'h0001, {15'b0, Ab_d});
        @(negedge clk);
        we = 1'b1; W_Adr = 3'd2; W = 16'h2222;
        edge_sample();
        pc("we_lock2_busy", 16'h0001, {15'b0, Rb_d});
        pc("we_lock2_R", 16'h2222, R_d);
        @(negedge clk);
        lock = 1'b0; W = 16'h3333;
        edge_sample();
        pc("we2_busy_clear", 16'h0000, {15'b0, Rb_d});
        pc("we2_any_clear", 16'h0000, {15'b0, Ab_d});
        @(negedge clk);
        we = 1'b0; lock = 1'b1; L_Adr = 3'd6; S_Adr = 3'd6;
        edge_sample();
        pc("lock6_S_busy", 16'h0001, {15'b0, Sb_d});
        @(negedge clk);
        flush = 1'b1; L_Adr = 3'd3; R_Adr = 3'd3;
        edge_sample();
        pc("flush_lock3_R_busy", 16'h0001, {15'b0, Rb_d});
        pc("flush_lock3_S6_busy", 16'h0000, {15'b0, Sb_d});
        pc("flush_lock3_any", 16'h0001, {15'b0, Ab_d});
        @(negedge clk);
        flush = 1'b0; lock = 1'b0; S_Adr = 3'd5;

        // Asynchronous reset mid-cycle.
        edge_sample();
        pc("pre_rst_R3", 16'hFFFC, R_d);
        pc("pre_rst_S5", 16'hA5A5, S_d);
        #2;
        reset = 1'b1; we = 1'b1; W_Adr = 3'd4; W = 16'hBEEF; lock = 1'b1; L_Adr = 3'd7;
        #1;
        pc("arst_R", 16'h0000, R_d);
        pc("arst_S", 16'h0000, S_d);
        pc("arst_busy", 16'h0000, {13'b0, Rb_d, Sb_d, Ab_d});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; we = 1'b0; lock = 1'b0; R_Adr = 3'd4; S_Adr = 3'd7;
        #1;
        pc("post_rst_R4", 16'h0000, R_d);
        pc("post_rst_any", 16'h0000, {15'b0, Ab_d});

        if (tag_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", tag_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
